// File: rtl/mod_113_sched.sv
// Round-robin scheduler feeding a serial 200-bit mod-113 reducer (one byte per cycle, MSB first).
// Latency: grant in cycle N -> res_valid in N+26; requests wait while busy, result holds until res_ready.
module mod_113_sched #(
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [200*NUM_REQ-1:0]   req_x,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [6:0]               res_r,
    output logic [1:0]               res_id,
    output logic                     busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t       r_state;
    logic [199:0] r_x;
    logic [6:0]   r_acc;
    logic [4:0]   r_cnt;
    logic [1:0]   r_last;
    logic [1:0]   r_id;
    logic         r_res_vld;
    logic         r_busy;
    logic [6:0]   r_res_r;
    logic [1:0]   r_res_id;

    logic         w_gnt_vld;
    logic [1:0]   w_gnt_id;
    int           w_idx;
    logic [14:0]  w_sum;
    logic [6:0]   w_acc_nxt;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        w_idx     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_idx = (int'(r_last) + j + 1) % NUM_REQ;
            if (!w_gnt_vld && req_valid[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = 2'(w_idx);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = rst_n && (r_state == S_IDLE) && w_gnt_vld && (w_gnt_id == 2'(j));
        end
    end

    // acc < 113 keeps acc*256 + byte below 113*256, so 15 bits suffice.
    assign w_sum     = {r_acc, 8'h00} + 15'(r_x[199:192]);
    assign w_acc_nxt = 7'(w_sum % 15'd113);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_last    <= 2'(NUM_REQ - 1);
            r_id      <= '0;
            r_res_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_res_r   <= '0;
            r_res_id  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_x     <= req_x[200*int'(w_gnt_id) +: 200];
                        r_id    <= w_gnt_id;
                        r_last  <= w_gnt_id;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_x   <= {r_x[191:0], 8'h00};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd24) begin
                        r_res_vld <= 1'b1;
                        r_res_r   <= w_acc_nxt;
                        r_res_id  <= r_id;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        r_res_vld <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_res_vld <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_vld;
    assign res_r     = r_res_r;
    assign res_id    = r_res_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mod_113_sched.sv
// Directed and randomised checks of mod_113_sched with a bitwise big-integer mod-113 reference.
module tb_mod_113_sched;

    localparam int NUM_REQ = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [200*NUM_REQ-1:0] req_x;
    logic                   res_valid;
    logic                   res_ready;
    logic [6:0]             res_r;
    logic [1:0]             res_id;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    mod_113_sched #(.NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_r     (res_r),
        .res_id    (res_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] ref_mod(input logic [199:0] x);
        int a;
        a = 0;
        for (int i = 199; i >= 0; i--) a = (a * 2 + int'(x[i])) % 113;
        return 7'(a);
    endfunction

    function automatic logic [199:0] rand200();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[32*i +: 32] = $urandom;
        return t[199:0];
    endfunction

    task automatic run_op(input int idx, input logic [199:0] x,
                          output logic [6:0] r, output logic [1:0] id,
                          output int lat, output bit ok);
        int t0;
        bit got;
        ok = 1'b0; r = '0; id = '0; lat = -1; got = 1'b0; t0 = 0;
        @(negedge clk);
        req_x[200*idx +: 200] = x;
        req_valid[idx] = 1'b1;
        res_ready = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (req_ready[idx]) begin
                got = 1'b1;
                t0 = cyc;
            end else begin
                @(negedge clk);
            end
        end
        if (!got) return;
        @(negedge clk);
        req_valid[idx] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin
                lat = cyc - t0; r = res_r; id = res_id; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; req_x = '0; res_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        n_vec++; if (res_r !== 7'd0) begin n_err++; $display("FAIL reset_res_r got %0d exp 0", res_r); end
        n_vec++; if (res_id !== 2'd0) begin n_err++; $display("FAIL reset_res_id got %0d exp 0", res_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [6:0] r; logic [1:0] id; int lat; bit ok;
        run_op(0, 200'd1000, r, id, lat, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout got no result exp result"); end
        n_vec++; if (lat !== 26) begin n_err++; $display("FAIL single_latency got %0d exp 26", lat); end
        n_vec++; if (r !== 7'd96) begin n_err++; $display("FAIL single_r got %0d exp 96", r); end
        n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL single_id got %0d exp 0", id); end
        @(negedge clk);
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse got %b exp 0", res_valid); end
        n_vec++; if (res_r !== 7'd96) begin n_err++; $display("FAIL single_hold_r got %0d exp 96", res_r); end
    endtask

    task automatic test_values();
        logic [199:0] xs[5];
        logic [6:0]   ex[5];
        logic [6:0] r; logic [1:0] id; int lat; bit ok;
        xs[0] = 200'd0;   ex[0] = 7'd0;
        xs[1] = 200'd113; ex[1] = 7'd0;
        xs[2] = 200'd112; ex[2] = 7'd112;
        xs[3] = 200'd256; ex[3] = 7'd30;
        xs[4] = '1;       ex[4] = ref_mod(xs[4]);
        for (int k = 0; k < 5; k++) begin
            run_op(k % 2, xs[k], r, id, lat, ok);
            n_vec++; if (!ok || r !== ex[k]) begin n_err++; $display("FAIL value_%0d got %0d exp %0d", k, r, ex[k]); end
            n_vec++; if (id !== 2'(k % 2)) begin n_err++; $display("FAIL value_id_%0d got %0d exp %0d", k, id, k % 2); end
            n_vec++; if (lat !== 26) begin n_err++; $display("FAIL value_lat_%0d got %0d exp 26", k, lat); end
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int         got_id[3];
        logic [6:0] got_r[3];
        int         nres;
        bit         drop1;
        int         exp_id[3];
        logic [6:0] exp_r[3];
        exp_id[0] = 0; exp_id[1] = 1; exp_id[2] = 0;
        exp_r[0] = 7'd30; exp_r[1] = 7'd96; exp_r[2] = 7'd30;
        for (int k = 0; k < 3; k++) begin got_id[k] = -1; got_r[k] = 'x; end
        nres = 0; drop1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        req_x[0 +: 200] = 200'd256;
        req_x[200 +: 200] = 200'd1000;
        req_valid = 2'b11;
        res_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rr_first_grant got %b exp 01", req_ready); end
        for (int c = 0; c < 120 && nres < 3; c++) begin
            if (drop1) req_valid[1] = 1'b0;
            #1;
            if (req_ready[1]) drop1 = 1'b1;
            if (res_valid) begin
                got_id[nres] = int'(res_id);
                got_r[nres] = res_r;
                nres++;
            end
            @(negedge clk);
        end
        n_vec++; if (nres !== 3) begin n_err++; $display("FAIL rr_count got %0d exp 3", nres); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (got_id[k] !== exp_id[k]) begin n_err++; $display("FAIL rr_id_%0d got %0d exp %0d", k, got_id[k], exp_id[k]); end
            n_vec++; if (got_r[k] !== exp_r[k]) begin n_err++; $display("FAIL rr_r_%0d got %0d exp %0d", k, got_r[k], exp_r[k]); end
        end
        drain();
    endtask

    task automatic test_backpressure();
        bit got;
        got = 1'b0;
        req_x[0 +: 200] = 200'd1000;
        req_x[200 +: 200] = 200'd1000;
        req_valid = 2'b01;
        res_ready = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (req_ready[0]) got = 1'b1; else @(negedge clk);
        end
        @(negedge clk);
        req_valid = 2'b10;
        for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            #1;
            n_vec++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_%0d got %b exp 1", c, res_valid); end
            n_vec++; if (res_r !== 7'd96 || res_id !== 2'd0) begin n_err++; $display("FAIL bp_data_%0d got r=%0d id=%0d exp r=96 id=0", c, res_r, res_id); end
            n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_req_ready_%0d got %b exp 00", c, req_ready); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_busy_%0d got %b exp 1", c, busy); end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got %b exp 0", res_valid); end
        n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL bp_held_req got %b exp 10", req_ready); end
        @(negedge clk);
        drain();
    endtask

    task automatic test_reset_mid_run();
        logic [6:0] r; logic [1:0] id; int lat; bit ok; bit got; bit seen;
        got = 1'b0; seen = 1'b0;
        req_x[0 +: 200] = 200'd1000;
        req_valid = 2'b01;
        res_ready = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            if (req_ready[0]) got = 1'b1; else @(negedge clk);
        end
        @(negedge clk);
        req_valid = '0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_ctrl got busy=%b vld=%b exp 0 0", busy, res_valid); end
        n_vec++; if (res_r !== 7'd0 || res_id !== 2'd0) begin n_err++; $display("FAIL mid_rst_data got r=%0d id=%0d exp 0 0", res_r, res_id); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (res_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_discard got result exp none"); end
        run_op(0, 200'd1000, r, id, lat, ok);
        n_vec++; if (!ok || r !== 7'd96) begin n_err++; $display("FAIL mid_rst_r got %0d exp 96", r); end
        n_vec++; if (lat !== 26) begin n_err++; $display("FAIL mid_rst_lat got %0d exp 26", lat); end
        n_vec++; if (id !== 2'd0) begin n_err++; $display("FAIL mid_rst_id got %0d exp 0", id); end
        drain();
    endtask

    task automatic test_random();
        logic [199:0]       px[NUM_REQ];
        bit                 pend[NUM_REQ];
        int                 q_id[$];
        logic [6:0]         q_r[$];
        int                 m_last;
        bit                 m_busy;
        logic [NUM_REQ-1:0] exp_rdy;
        int                 done;
        int                 e_id;
        logic [6:0]         e_r;
        bit                 found;
        int                 g;
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = NUM_REQ - 1; m_busy = 1'b0; done = 0;
        for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 1'b0; px[i] = '0; end
        for (int c = 0; c < 60000 && done < 1000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    px[i] = ($urandom_range(0, 9) == 0) ? '1 : rand200();
                    req_x[200*i +: 200] = px[i];
                end
                req_valid[i] = pend[i];
            end
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = '0; found = 1'b0; g = 0;
            if (!m_busy) begin
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!found && pend[(m_last + 1 + j) % NUM_REQ]) begin
                        found = 1'b1;
                        g = (m_last + 1 + j) % NUM_REQ;
                        exp_rdy[g] = 1'b1;
                    end
                end
            end
            n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_req_ready cyc %0d got %b exp %b", c, req_ready, exp_rdy); end
            n_vec++; if (busy !== m_busy) begin n_err++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy, m_busy); end
            if (found) begin
                q_id.push_back(g);
                q_r.push_back(ref_mod(px[g]));
                m_last = g; pend[g] = 1'b0; m_busy = 1'b1;
            end
            if (res_valid && res_ready) begin
                n_vec++;
                if (q_id.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra_result got id=%0d r=%0d exp none", res_id, res_r);
                end else begin
                    e_id = q_id.pop_front();
                    e_r = q_r.pop_front();
                    if (int'(res_id) !== e_id || res_r !== e_r) begin
                        n_err++; $display("FAIL rnd_result %0d got id=%0d r=%0d exp id=%0d r=%0d", done, res_id, res_r, e_id, e_r);
                    end
                end
                done++; m_busy = 1'b0;
            end
        end
        n_vec++; if (done !== 1000) begin n_err++; $display("FAIL rnd_completed got %0d exp 1000", done); end
        n_vec++; if (q_id.size() !== 0) begin n_err++; $display("FAIL rnd_lost got %0d pending exp 0", q_id.size()); end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_values();
        test_round_robin();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mod_113_sched.md
MOD_113_SCHED -- requirements
Module: mod_113_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters; legal 2..4.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, NUM_REQ, per-requester operand valid.
REQ-005 SHALL have port req_ready, output, NUM_REQ, per-requester accept strobe, at most one bit high.
REQ-006 SHALL have port req_x, input, 200*NUM_REQ, requester i operand at bits [200*i+199 : 200*i], unsigned.
REQ-007 SHALL have port res_valid, output, 1, result valid.
REQ-008 SHALL have port res_ready, input, 1, result consumer ready.
REQ-009 SHALL have port res_r, output, 7, operand mod 113.
REQ-010 SHALL have port res_id, output, 2, index of requester that owns res_r.
REQ-011 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; encoding free.
REQ-013 IDLE: if any req_valid high, SHALL grant one requester and drive only its req_ready high combinationally in that cycle; otherwise all req_ready low.
REQ-014 Grant SHALL be round-robin: search starts at index (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 wins first.
REQ-015 Handshake (req_valid[i] & req_ready[i]) SHALL latch req_x slice i and id i, clear accumulator acc to 0, clear chunk counter to 0, update last_grant to i, enter RUN.
REQ-016 req_ready SHALL be all-zero in RUN and DONE; requests are held off, never dropped.
REQ-017 RUN: each cycle SHALL compute acc <= (acc*256 + chunk_k) mod 113, chunk_k = operand bits [199-8k : 192-8k] (MSB chunk first), k = counter 0..24.
REQ-018 Intermediate acc*256+chunk SHALL be 15 bits wide (max 28927); acc SHALL always be < 113 after each update.
REQ-019 After the update with k = 24, SHALL enter DONE; RUN lasts exactly 25 cycles.
REQ-020 Handshake in cycle N SHALL give res_valid high from cycle N+26.
REQ-021 DONE: res_valid high; res_r = acc, res_id = latched id, both stable while res_valid & !res_ready.
REQ-022 res_valid & res_ready SHALL return FSM to IDLE next cycle; res_valid low in IDLE and RUN.
REQ-023 A new handshake SHALL be possible in the first IDLE cycle after result handshake; minimum period 27 cycles per operation.
REQ-024 req_valid changes while not granted SHALL have no effect; requester dropping req_valid before grant is simply skipped.
REQ-025 res_r and res_id SHALL hold their last values in IDLE and RUN (only res_valid qualifies them).

Reset
REQ-026 rst_n low SHALL immediately force IDLE, req_ready 0, res_valid 0, res_r 0, res_id 0, busy 0, acc 0, counter 0, last_grant NUM_REQ-1.
REQ-027 Reset during RUN or DONE SHALL discard the in-flight operand; no result SHALL be produced for it.
REQ-028 Reset deassertion SHALL be accepted on any clock edge; first grant possible in first cycle after release.

Verification
REQ-029 Single req 0, x = 1000, res_ready = 1 -> res_valid at N+26, res_r = 96, res_id = 0, one-cycle res_valid pulse.
REQ-030 Values x = 0 -> 0, x = 113 -> 0, x = 112 -> 112, x = 256 -> 30, x = 2^200-1 -> matches bench reference model (big-integer mod 113).
REQ-031 Both requesters valid from reset with x0 = 256, x1 = 1000 -> first result id 0, r 30; second result id 1, r 96; then req 0 again if still valid (round-robin).
REQ-032 res_ready low for 10 cycles in DONE -> res_valid, res_r, res_id stable, req_ready all 0, busy 1; completes on first res_ready high.
REQ-033 rst_n pulsed low at RUN cycle 10 -> all outputs at reset values immediately; subsequent request x = 1000 yields 96 with correct latency.
REQ-034 Random regression, 1000 operations, random valid/ready backpressure -> every result equals reference model, ids follow round-robin order, no request lost or duplicated.
